// File: rtl/wb_sram_slave.sv
// ---------------------------------------------------------------------------
// wb_sram_slave
//
// Wishbone B3 slave serving classic and burst cycles from an on-chip,
// read-synchronous 32-bit word RAM of 2^ADDR_BITS words. It is the boot and
// scratch memory target on the system bus, and the responder for the ICMU and
// DCMU cache-line fills.
//
// Burst addresses (linear or 4/8/16-beat wrap) are generated internally from
// the address latched at the start of the cycle. WAIT_STATES extra cycles
// (0-7) are inserted before the first ack of every cycle.
//
// Optional feature macro: WB_SRAM_ERR_EN
//   defined   - a cycle addressing beyond the RAM (wbs_addr_i[29:ADDR_BITS]
//               nonzero, or a linear burst running off the top) is answered
//               with wbs_err_o instead of wbs_ack_o, and nothing is written.
//   undefined - wbs_err_o is tied low and the RAM aliases across the space.
//
// Parameters:
//   ADDR_BITS   - word address width (must be > 4 so a 16-beat wrap fits)
//   WAIT_STATES - wait cycles before the first ack (0-7)
//
// Ports:
//   clk         - clock, all logic on the rising edge
//   rst         - synchronous reset, active low
//   wbs_cyc_i   - bus cycle valid
//   wbs_stb_i   - strobe
//   wbs_addr_i  - word address (byte address bits [31:2])
//   wbs_cti_i   - cycle type: 010 incrementing burst, 111 end, else classic
//   wbs_bte_i   - burst type: 00 linear, 01/10/11 4/8/16-beat wrap
//   wbs_sel_i   - byte enables
//   wbs_we_i    - write enable
//   wbs_data_i  - write data
//   wbs_data_o  - read data, valid while ack is high
//   wbs_ack_o   - acknowledge
//   wbs_err_o   - error (only with WB_SRAM_ERR_EN)
// ---------------------------------------------------------------------------
module wb_sram_slave #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic [29:0] wbs_addr_i,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_data_i,
   output logic [31:0] wbs_data_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o
);

   localparam int         DEPTH     = 1 << ADDR_BITS;
   localparam logic [2:0] CTI_INCR  = 3'b010;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_BURST,
      S_DONE
   } state_t;

   state_t               state, state_next;
   logic [ADDR_BITS-1:0] addr_r, addr_next, addr_inc, rd_addr;
   logic [1:0]           bte_r, bte_next;
   logic                 we_r, we_next;
   logic                 burst_r, burst_next;
   logic [2:0]           wait_cnt, wait_cnt_next;
   logic                 ack_r;
   logic                 beat;
   logic                 blocked;
   logic                 wr_en;
   logic                 rd_en;

   logic [31:0]          mem [DEPTH];

   // A beat completes only while the master is strobing inside a live cycle.
   assign beat = ack_r & wbs_cyc_i & wbs_stb_i;

   // Next burst address: wrap modes only count inside the aligned block,
   // linear mode rolls over at the top of the RAM.
   always_comb begin
      addr_inc = addr_r + ADDR_BITS'(1);
      case (bte_r)
         2'b01:   addr_inc = {addr_r[ADDR_BITS-1:2], addr_r[1:0] + 2'd1};
         2'b10:   addr_inc = {addr_r[ADDR_BITS-1:3], addr_r[2:0] + 3'd1};
         2'b11:   addr_inc = {addr_r[ADDR_BITS-1:4], addr_r[3:0] + 4'd1};
         default: ;
      endcase
   end

   // Next-state logic. The RAM read address is chosen here so that the word
   // for the coming ack cycle is fetched one cycle ahead: the incoming address
   // while idle, the advanced address on an acked burst beat, otherwise the
   // held address (a stalled beat simply re-reads the same word).
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_next    = state;
      addr_next     = addr_r;
      bte_next      = bte_r;
      we_next       = we_r;
      burst_next    = burst_r;
      wait_cnt_next = wait_cnt;
      rd_addr       = addr_r;

      case (state)
         S_IDLE: begin
            rd_addr = wbs_addr_i[ADDR_BITS-1:0];
            if (wbs_cyc_i && wbs_stb_i) begin
               addr_next     = wbs_addr_i[ADDR_BITS-1:0];
               bte_next      = wbs_bte_i;
               we_next       = wbs_we_i;
               burst_next    = (wbs_cti_i == CTI_INCR);
               wait_cnt_next = WAIT_INIT;
               if (WAIT_INIT != 3'd0)
                  state_next = S_WAIT;
               else if (wbs_cti_i == CTI_INCR)
                  state_next = S_BURST;
               else
                  state_next = S_ACK;
            end
         end

         S_WAIT: begin
            wait_cnt_next = wait_cnt - 3'd1;
            if (!wbs_cyc_i)
               state_next = S_IDLE;
            else if (wait_cnt == 3'd1)
               state_next = burst_r ? S_BURST : S_ACK;
         end

         S_ACK: begin
            state_next = wbs_cyc_i ? S_DONE : S_IDLE;
         end

         S_BURST: begin
            if (!wbs_cyc_i) begin
               state_next = S_IDLE;
            end else if (wbs_stb_i) begin
               addr_next = addr_inc;
               rd_addr   = addr_inc;
               // End-of-burst, classic and reserved cti values all close the
               // burst after this beat.
               if (wbs_cti_i != CTI_INCR)
                  state_next = S_DONE;
            end
         end

         S_DONE: begin
            // Waiting for stb to drop keeps a classic master that still holds
            // stb from seeing a second ack.
            if (!wbs_cyc_i || !wbs_stb_i)
               state_next = S_IDLE;
         end

         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (!rst) begin
         state    <= S_IDLE;
         addr_r   <= '0;
         bte_r    <= 2'b00;
         we_r     <= 1'b0;
         burst_r  <= 1'b0;
         wait_cnt <= 3'd0;
         ack_r    <= 1'b0;
      end else begin
         state    <= state_next;
         addr_r   <= addr_next;
         bte_r    <= bte_next;
         we_r     <= we_next;
         burst_r  <= burst_next;
         wait_cnt <= wait_cnt_next;
         ack_r    <= (state_next == S_ACK) || (state_next == S_BURST);
      end
   end

`ifdef WB_SRAM_ERR_EN
   logic oob_r;
   logic oob_next;

   // Out-of-range flag: set from the high address bits at acceptance, and
   // set once a linear burst steps past the last word.
   always_comb begin
      oob_next = oob_r;
      if (state == S_IDLE)
         oob_next = |wbs_addr_i[29:ADDR_BITS];
      else if (state == S_BURST && beat && bte_r == 2'b00 && &addr_r)
         oob_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         oob_r <= 1'b0;
      else
         oob_r <= oob_next;
   end

   assign blocked   = oob_r;
   assign wbs_ack_o = beat & ~oob_r;
   assign wbs_err_o = beat & oob_r;
`else
   logic unused_high_addr;
   assign unused_high_addr = ^wbs_addr_i[29:ADDR_BITS];

   assign blocked   = 1'b0;
   assign wbs_ack_o = beat;
   assign wbs_err_o = 1'b0;
`endif

   // A beat coinciding with reset is dropped so a reset burst writes nothing.
   assign wr_en = beat & we_r & rst & ~blocked;
   assign rd_en = (state_next == S_ACK) || (state_next == S_BURST);

   // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
   // inference, and its contents are meant to survive reset anyway.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b])
               mem[addr_r][8*b +: 8] <= wbs_data_i[8*b +: 8];
         end
      end
   end

   // Output register: loaded only when an ack cycle follows, so the bus data
   // holds its last value between transfers.
   always_ff @(posedge clk) begin
      if (!rst)
         wbs_data_o <= '0;
      else if (rd_en)
         wbs_data_o <= mem[rd_addr];
   end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Wishbone B3 slave that serves single and burst cycles from an on-chip synchronous word RAM. It is the responder for the ICMU and DCMU cache-line master ports. It decodes `cti`/`bte`, generates burst addresses internally, inserts programmable wait states, and applies byte-lane writes. It sits on the system bus as the boot/scratch memory target.

## Interface
- `ADDR_BITS`, 10: word address width; RAM depth is 2^ADDR_BITS × 32 bits.
- `WAIT_STATES`, 0: extra cycles (0–7) inserted before the first ack of every cycle.
- `clk` in 1: main clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `wbs_cyc_i` in 1: bus cycle valid.
- `wbs_stb_i` in 1: strobe.
- `wbs_addr_i` in 30: word address [31:2]; bits [ADDR_BITS+1:2] index the RAM.
- `wbs_cti_i` in 3: 000 classic, 010 incrementing burst, 111 end of burst; other values are treated as 000.
- `wbs_bte_i` in 2: 00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap.
- `wbs_sel_i` in 4: byte enables; bit n selects data[8n+7:8n].
- `wbs_we_i` in 1: write.
- `wbs_data_i` in 32: write data.
- `wbs_data_o` out 32: read data, valid while ack is high.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_err_o` out 1: error; constant 0 unless `WB_SRAM_ERR_EN` is defined.

## Operation
- State machine: IDLE, WAIT, ACK, BURST, DONE.
- **IDLE**
  - On `cyc&stb`, latch `addr`, `bte` and `we`, and load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise to ACK or BURST.
  - ACK is chosen when cti≠010. BURST is chosen when cti=010.
- **WAIT**: decrement the counter. When it reaches 0, go to ACK or BURST, using the cti sampled at entry.
- **ACK** (classic single transfer): ack is high for exactly one cycle, then go to DONE.
- **BURST**
  - Ack is high every cycle while `cyc&stb`.
  - The internal address advances after each acked beat.
  - Leave BURST after the beat acked with cti=111, or when `cyc` falls; go to DONE.
  - If cti changes to 000 mid-burst, that beat is acked and treated as the last.
- **DONE**: ack stays low. Return to IDLE when `stb` is low or `cyc` is low. This prevents a double-ack of a classic cycle.
- **Ack gating**: `wbs_ack_o = ack_r & wbs_cyc_i & wbs_stb_i`. A beat is only acked while the master strobes.
- **Burst address generation** (k = 2, 3 or 4 for bte 01/10/11):
  - Next address is `{a[ADDR_BITS-1:k], a[k-1:0]+1}`, so it wraps inside the aligned 2^k-word block.
  - For bte=00 the next address is a+1 modulo 2^ADDR_BITS, wrapping at the top of the RAM.
- **Read**: the RAM is read-synchronous. The address for beat n+1 is presented during beat n, so data is valid in the same cycle as each ack. `wbs_data_o` holds its last value otherwise.
- **Write**: on an acked beat with we=1, bytes are written per `sel`. Bytes with sel=0 are unchanged. `wbs_data_o` is undefined during writes.
- **Master abort**: if `cyc` drops in any non-IDLE state, go to IDLE the next cycle with no further ack and no write.
- **Reset**: state=IDLE, ack_r=0, `wbs_err_o`=0, `wbs_data_o`=0, wait counter=0. RAM contents are not cleared. Reset mid-burst aborts the burst with no further writes.

## Timing
- Classic read/write: `stb` seen at cycle 0 → ack at cycle 1+WAIT_STATES for one cycle → DONE.
- Minimum spacing between classic cycles is 3 cycles at WAIT_STATES=0: ack, DONE, then IDLE re-accepts.
- Burst of N beats: first ack at cycle 1+WAIT_STATES, then one beat per cycle → last ack at cycle N+WAIT_STATES.
- Burst beats held off by stb=0: the address does not advance, ack is low, and the burst resumes when stb returns.

## Configuration
- `WB_SRAM_ERR_EN` defined:
  - A cycle whose `wbs_addr_i[29:ADDR_BITS]` is nonzero is answered with `wbs_err_o` in place of ack, with the same timing as ack.
  - No RAM write occurs. A burst that runs off the top of the RAM errs on its remaining beats.
- Not defined: `wbs_err_o` is tied to 0. High address bits are ignored, so the RAM aliases across the address space.

## Test plan
- Classic write 0xDEADBEEF to word 0x10 with sel=1111, then a classic read with WAIT_STATES=0 → ack 1 cycle after stb and data 0xDEADBEEF. DONE blocks a second ack while stb is still high.
- Byte write sel=0010, data 0x0000AB00, to a word holding 0x11223344 → read returns 0x1122AB44.
- 4-beat wrap read (bte=01) starting at word 0x06, with words 4–7 preloaded to 4,5,6,7 → data 6,7,4,5 on four consecutive acks at cycles 1–4; cti=111 on beat 4 → ack low at cycle 5.
- Linear burst with WAIT_STATES=2, stb deasserted for 2 cycles after beat 2 → first ack at cycle 3, no ack during the gap, beat 3 returns word base+2.
- Master drops cyc mid-write-burst after beat 2 → beats 1–2 written, beat 3 not written, state back in IDLE after 1 cycle. Assert rst=0 during a burst → ack=0 the next cycle.
- With `WB_SRAM_ERR_EN` and ADDR_BITS=10, access word 0x400 → `wbs_err_o`=1 at cycle 1, ack stays 0, and the contents of word 0x000 are unchanged.
